// File: rtl/ram_burst_writer.sv
// Burst RAM loader (optional XOR checksum via RAM_BURST_WRITER_CHECKSUM_EN) with a synchronous read port.
// Latency: start->write_ready 1 cycle, last beat->done 1 cycle, read data 1 cycle after read_enable.
// Backpressure: write_ready is high only in WRITE; write_valid low stalls indefinitely, start ignored while busy.
module ram_burst_writer #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int MEMORY_DEPTH  = 256
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_address,
    input  logic [ADDRESS_WIDTH-1:0] burst_length,
    input  logic                     write_valid,
    input  logic [DATA_WIDTH-1:0]    write_data,
    output logic                     write_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    input  logic                     read_enable,
    input  logic [ADDRESS_WIDTH-1:0] read_address,
`ifdef RAM_BURST_WRITER_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0]    checksum,
`endif
    output logic [DATA_WIDTH-1:0]    read_data
);

    localparam int unsigned DEPTH_U = MEMORY_DEPTH;
    localparam int IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                   state, state_nxt;
    logic [ADDRESS_WIDTH-1:0] ptr, ptr_nxt;
    logic [ADDRESS_WIDTH-1:0] remaining, remaining_nxt;
    logic [ADDRESS_WIDTH-1:0] ptr_inc;
    logic                     done_nxt, error_nxt;
    logic                     beat, base_oob, inc_oob;

    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

    assign ptr_inc     = ptr + ADDRESS_WIDTH'(1);
    assign base_oob    = 32'(base_address) >= DEPTH_U;
    // Running off the end (including modulo wrap to 0) mid-burst aborts the burst.
    assign inc_oob     = (ptr_inc == '0) || (32'(ptr_inc) >= DEPTH_U);
    assign write_ready = (state == WRITE);
    assign beat        = write_ready && write_valid;
    assign busy        = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            remaining <= remaining_nxt;
            done      <= done_nxt;
            error     <= error_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        remaining_nxt = remaining;
        done_nxt      = 1'b0;
        error_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    ptr_nxt       = base_address;
                    remaining_nxt = burst_length;
                    if (burst_length == '0) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else if (base_oob) begin
                        error_nxt = 1'b1;
                    end else begin
                        state_nxt = WRITE;
                    end
                end
            end
            WRITE: begin
                if (beat) begin
                    ptr_nxt       = ptr_inc;
                    remaining_nxt = remaining - ADDRESS_WIDTH'(1);
                    if (remaining == ADDRESS_WIDTH'(1)) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else if (inc_oob) begin
                        state_nxt = IDLE;
                        error_nxt = 1'b1;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Array is deliberately not reset so it maps onto plain RAM macros.
    always_ff @(posedge clock) begin
        if (beat) begin
            mem[ptr[IDX_W-1:0]] <= write_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_data <= '0;
        end else if (read_enable) begin
            read_data <= (32'(read_address) < DEPTH_U) ? mem[read_address[IDX_W-1:0]] : '0;
        end
    end

`ifdef RAM_BURST_WRITER_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if (state == IDLE && start) begin
            checksum <= '0;
        end else if (beat) begin
            checksum <= checksum ^ write_data;
        end
    end
`endif

endmodule

// File: tb/tb_ram_burst_writer.sv
// Directed bench for ram_burst_writer: a 256-deep instance (a_*) and a 16-deep instance (b_*).
module tb_ram_burst_writer;

    logic       clock = 1'b0;
    logic       reset_n;
    int         total = 0;
    int         passes = 0;

    logic       a_start, a_write_valid, a_write_ready, a_busy, a_done, a_error, a_read_enable;
    logic [7:0] a_base_address, a_burst_length, a_write_data, a_read_address, a_read_data;
    logic       b_start, b_write_valid, b_write_ready, b_busy, b_done, b_error, b_read_enable;
    logic [7:0] b_base_address, b_burst_length, b_write_data, b_read_address, b_read_data;
`ifdef RAM_BURST_WRITER_CHECKSUM_EN
    logic [7:0] a_checksum, b_checksum;
`endif

    logic [7:0] v1 [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [7:0] v2 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    always #5 clock = ~clock;

    ram_burst_writer #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8), .MEMORY_DEPTH(256)) dut_a (
        .clock(clock), .reset_n(reset_n), .start(a_start),
        .base_address(a_base_address), .burst_length(a_burst_length),
        .write_valid(a_write_valid), .write_data(a_write_data), .write_ready(a_write_ready),
        .busy(a_busy), .done(a_done), .error(a_error),
        .read_enable(a_read_enable), .read_address(a_read_address),
`ifdef RAM_BURST_WRITER_CHECKSUM_EN
        .checksum(a_checksum),
`endif
        .read_data(a_read_data)
    );

    ram_burst_writer #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8), .MEMORY_DEPTH(16)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(b_start),
        .base_address(b_base_address), .burst_length(b_burst_length),
        .write_valid(b_write_valid), .write_data(b_write_data), .write_ready(b_write_ready),
        .busy(b_busy), .done(b_done), .error(b_error),
        .read_enable(b_read_enable), .read_address(b_read_address),
`ifdef RAM_BURST_WRITER_CHECKSUM_EN
        .checksum(b_checksum),
`endif
        .read_data(b_read_data)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic rd_a(input logic [7:0] addr, input logic [7:0] exp, input string tag);
        a_read_enable  = 1'b1;
        a_read_address = addr;
        tick();
        chk(tag, a_read_data, exp);
        a_read_enable  = 1'b0;
    endtask

    task automatic rd_b(input logic [7:0] addr, input logic [7:0] exp, input string tag);
        b_read_enable  = 1'b1;
        b_read_address = addr;
        tick();
        chk(tag, b_read_data, exp);
        b_read_enable  = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        a_start = 0; a_base_address = 0; a_burst_length = 0; a_write_valid = 0; a_write_data = 0;
        a_read_enable = 0; a_read_address = 0;
        b_start = 0; b_base_address = 0; b_burst_length = 0; b_write_valid = 0; b_write_data = 0;
        b_read_enable = 0; b_read_address = 0;
        #1;
        chk("rst_ready", a_write_ready, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_error", a_error, 0);
        chk("rst_rdata", a_read_data, 0);
        #11 reset_n = 1'b1;
        tick();

        // Back-to-back 4-word burst at 0x10.
        a_start = 1; a_base_address = 8'h10; a_burst_length = 8'd4;
        tick();
        chk("t1_ready", a_write_ready, 1);
        chk("t1_busy", a_busy, 1);
        a_start = 0; a_write_valid = 1;
        for (int i = 0; i < 4; i++) begin
            a_write_data = v1[i];
            tick();
            if (i < 3) chk("t1_nodone", a_done, 0);
        end
        chk("t1_done", a_done, 1);
        chk("t1_done_busy", a_busy, 1);
        chk("t1_done_ready", a_write_ready, 0);
        chk("t1_done_err", a_error, 0);
`ifdef RAM_BURST_WRITER_CHECKSUM_EN
        chk("t1_checksum", a_checksum, 8'h04);
`endif
        a_write_valid = 0;
        tick();
        chk("t1_done_gone", a_done, 0);
        chk("t1_idle", a_busy, 0);
        for (int i = 0; i < 4; i++) rd_a(8'h10 + 8'(i), v1[i], "t1_read");
        a_read_address = 8'h10;
        tick();
        chk("t1_read_hold", a_read_data, 8'hD4);

        // Same burst shape with valid toggling; stalled cycles carry junk data.
        a_start = 1; a_base_address = 8'h20; a_burst_length = 8'd4;
        tick();
        a_start = 0;
        for (int i = 0; i < 4; i++) begin
            a_write_valid = 1; a_write_data = v2[i];
            tick();
            chk("t2_busy", a_busy, 1);
            if (i < 3) begin
                a_write_valid = 0; a_write_data = 8'hEE;
                tick();
                chk("t2_stall_busy", a_busy, 1);
                chk("t2_stall_nodone", a_done, 0);
            end
        end
        chk("t2_done", a_done, 1);
        a_write_valid = 0;
        tick();
        for (int i = 0; i < 4; i++) rd_a(8'h20 + 8'(i), v2[i], "t2_read");

        // Empty burst.
        a_start = 1; a_base_address = 8'h10; a_burst_length = 8'd0;
        tick();
        chk("t3_done", a_done, 1);
        chk("t3_busy", a_busy, 1);
        chk("t3_ready", a_write_ready, 0);
        a_start = 0;
        tick();
        chk("t3_done_gone", a_done, 0);
        chk("t3_idle", a_busy, 0);
        rd_a(8'h10, 8'hA1, "t3_mem_kept");

        // Depth-16 instance: seed mem[0..1], then overrun from base 14.
        b_start = 1; b_base_address = 8'd0; b_burst_length = 8'd2;
        tick();
        b_start = 0; b_write_valid = 1;
        b_write_data = 8'h5A; tick();
        b_write_data = 8'h5B; tick();
        chk("t4_seed_done", b_done, 1);
        b_write_valid = 0;
        tick();
        b_start = 1; b_base_address = 8'd14; b_burst_length = 8'd4;
        tick();
        b_start = 0; b_write_valid = 1;
        b_write_data = 8'hE0; tick();
        chk("t4_beat1_err", b_error, 0);
        chk("t4_beat1_ready", b_write_ready, 1);
        b_write_data = 8'hE1; tick();
        chk("t4_err", b_error, 1);
        chk("t4_err_nodone", b_done, 0);
        chk("t4_err_ready", b_write_ready, 0);
        chk("t4_err_busy", b_busy, 0);
        b_write_data = 8'hE2; tick();
        chk("t4_after_ready", b_write_ready, 0);
        chk("t4_err_pulse", b_error, 0);
        b_write_valid = 0;
        rd_b(8'd14, 8'hE0, "t4_mem14");
        rd_b(8'd15, 8'hE1, "t4_mem15");
        rd_b(8'd0, 8'h5A, "t4_mem0");
        rd_b(8'd1, 8'h5B, "t4_mem1");
        rd_b(8'd20, 8'h00, "t4_read_oob");

        // Out-of-range base.
        b_start = 1; b_base_address = 8'd20; b_burst_length = 8'd3;
        tick();
        chk("t5_err", b_error, 1);
        chk("t5_busy", b_busy, 0);
        chk("t5_ready", b_write_ready, 0);
        b_start = 0;
        tick();
        chk("t5_err_pulse", b_error, 0);
        chk("t5_busy2", b_busy, 0);

        // Asynchronous reset after 2 beats of a 4-word burst.
        a_start = 1; a_base_address = 8'h40; a_burst_length = 8'd4;
        tick();
        a_start = 0; a_write_valid = 1;
        a_write_data = 8'h71; tick();
        a_write_data = 8'h72; tick();
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_ready", a_write_ready, 0);
        chk("t6_rst_busy", a_busy, 0);
        chk("t6_rst_done", a_done, 0);
        chk("t6_rst_err", a_error, 0);
        chk("t6_rst_rdata", a_read_data, 0);
        a_write_valid = 0;
        reset_n = 1'b1;
        tick();
        chk("t6_no_done", a_done, 0);
        chk("t6_no_err", a_error, 0);
        rd_a(8'h40, 8'h71, "t6_kept0");
        rd_a(8'h41, 8'h72, "t6_kept1");

        // New burst accepted; start held high while busy must be ignored.
        a_start = 1; a_base_address = 8'h50; a_burst_length = 8'd1;
        tick();
        chk("t7_ready", a_write_ready, 1);
        a_base_address = 8'h60; a_burst_length = 8'd2;
        a_write_valid = 1; a_write_data = 8'h99;
        tick();
        chk("t7_done", a_done, 1);
        a_start = 0; a_write_valid = 0;
        tick();
        chk("t7_idle", a_busy, 0);
        chk("t7_done_gone", a_done, 0);
        rd_a(8'h50, 8'h99, "t7_mem");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
